window_motor_ctrl: RTL and testbench

Multi-channel successor to the single-window open/close FSM. Each of NUM_CH windows gets its own motor FSM with press-to-stop, press-to-reverse, end-stop limit switches and a travel timeout fault. Sits between synchronous button/limit inputs and the motor driver pins (open_cw/close_ccw per channel). Outputs are Moore-decoded from registered state, so motor drives are glitch-free.

---
 rtl/window_motor_ctrl_if.sv | 24 ++
 rtl/window_motor_ctrl.sv | 141 ++++++++++++++
 tb/tb_window_motor_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_motor_ctrl_if.sv
// Bundle of per-channel button/limit inputs and motor drive outputs for window_motor_ctrl.
// The slave modport is the controller side; master is whatever drives buttons and limits.
interface window_motor_ctrl_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   button_press;
  logic [NUM_CH-1:0]   limit_open;
  logic [NUM_CH-1:0]   limit_closed;
  logic                fault_clr;
  logic [NUM_CH-1:0]   open_cw;
  logic [NUM_CH-1:0]   close_ccw;
  logic [3*NUM_CH-1:0] state_o;
  logic [NUM_CH-1:0]   fault;

  modport master (
    output button_press, limit_open, limit_closed, fault_clr,
    input  open_cw, close_ccw, state_o, fault
  );

  modport slave (
    input  button_press, limit_open, limit_closed, fault_clr,
    output open_cw, close_ccw, state_o, fault
  );
endinterface

// File: rtl/window_motor_ctrl.sv
// NUM_CH independent window motor FSMs with press-to-stop/reverse, end-stops and travel timeout.
// Drives are Moore-decoded from the registered state so motor pins never glitch.
//
// state   | meaning
// CLOSED  | window at closed end-stop, motor off
// OPENING | open_cw driven, travel counter running
// OPENED  | window at open end-stop, motor off
// CLOSING | close_ccw driven, travel counter running
// STOPPED | halted mid-travel, next press reverses last direction
// FAULT   | timeout or both limits seen; only fault_clr releases it
module window_motor_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 16,
  parameter int TRAVEL_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               n_reset,
  window_motor_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPENED  = 3'd2,
    CLOSING = 3'd3,
    STOPPED = 3'd4,
    FAULT   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NUM_CH-1:0] btn_s1, btn_s2, btn_s2_q;
  logic [NUM_CH-1:0] lo_s1, lo_s2;
  logic [NUM_CH-1:0] lc_s1, lc_s2;
  logic [NUM_CH-1:0] press_evt;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  // 1 = last interrupted travel was opening, so the next press from STOPPED closes
  logic [NUM_CH-1:0] dir_open_q, dir_open_d;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_s2_q <= '0;
      lo_s1    <= '0;
      lo_s2    <= '0;
      lc_s1    <= '0;
      lc_s2    <= '0;
    end else begin
      btn_s1   <= bus.button_press;
      btn_s2   <= btn_s1;
      btn_s2_q <= btn_s2;
      lo_s1    <= bus.limit_open;
      lo_s2    <= lo_s1;
      lc_s1    <= bus.limit_closed;
      lc_s2    <= lc_s1;
    end
  end

  assign press_evt = btn_s2 & ~btn_s2_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CLOSED;
        cnt_q[i]   <= '0;
      end
      dir_open_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      dir_open_q <= dir_open_d;
    end
  end

  always_comb begin
    dir_open_d = dir_open_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      case (state_q[i])
        CLOSED: begin
          if (press_evt[i]) state_d[i] = OPENING;
        end
        OPENING: begin
          if (lo_s2[i] && lc_s2[i])     state_d[i] = FAULT;
          else if (lo_s2[i])            state_d[i] = OPENED;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = FAULT;
          else if (press_evt[i]) begin
            state_d[i]    = STOPPED;
            dir_open_d[i] = 1'b1;
          end
        end
        OPENED: begin
          if (press_evt[i]) state_d[i] = CLOSING;
        end
        CLOSING: begin
          if (lo_s2[i] && lc_s2[i])     state_d[i] = FAULT;
          else if (lc_s2[i])            state_d[i] = CLOSED;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = FAULT;
          else if (press_evt[i]) begin
            state_d[i]    = STOPPED;
            dir_open_d[i] = 1'b0;
          end
        end
        STOPPED: begin
          if (press_evt[i]) state_d[i] = dir_open_q[i] ? CLOSING : OPENING;
        end
        FAULT: begin
          if (bus.fault_clr) begin
            state_d[i]    = STOPPED;
            dir_open_d[i] = 1'b1;
          end
        end
        default: state_d[i] = FAULT;
      endcase

      // Fresh count on every entry into a moving state; saturate while moving
      if ((state_d[i] == OPENING || state_d[i] == CLOSING) && state_d[i] != state_q[i])
        cnt_d[i] = '0;
      else if ((state_q[i] == OPENING || state_q[i] == CLOSING) && cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.open_cw[g]         = (state_q[g] == OPENING);
    assign bus.close_ccw[g]       = (state_q[g] == CLOSING);
    assign bus.fault[g]           = (state_q[g] == FAULT);
    assign bus.state_o[3*g +: 3]  = state_q[g];
  end

endmodule

// File: tb/tb_window_motor_ctrl.sv
// Self-checking bench for window_motor_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural per-channel window model.
module tb_window_motor_ctrl;
  localparam int NUM_CH = 2;
  localparam int TRAVEL = 16;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  window_motor_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  window_motor_ctrl #(
    .NUM_CH(NUM_CH),
    .CNT_W(16),
    .TRAVEL_CYCLES(TRAVEL)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: window position as a state code, cycles driven in the current move,
  // where a press from STOPPED heads, and raw input samples from recent edges.
  int m_state  [NUM_CH];
  int m_drv    [NUM_CH];
  int m_resume [NUM_CH];
  bit hb [NUM_CH][3];
  bit ho [NUM_CH][3];
  bit hc [NUM_CH][3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_state[c]  = 0;
      m_drv[c]    = 0;
      m_resume[c] = 1;
      for (int k = 0; k < 3; k++) begin
        hb[c][k] = 1'b0;
        ho[c][k] = 1'b0;
        hc[c][k] = 1'b0;
      end
    end
  endfunction

  // Called right after each rising edge; inputs are stable there (driven at negedge)
  function automatic void model_step();
    bit press, lo, lc, tgt;
    if (!n_reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      // An input level reaches the FSM two edges after it is first sampled
      press = hb[c][1] && !hb[c][2];
      lo    = ho[c][1];
      lc    = hc[c][1];
      case (m_state[c])
        0: if (press) begin m_state[c] = 1; m_drv[c] = 0; end
        2: if (press) begin m_state[c] = 3; m_drv[c] = 0; end
        1, 3: begin
          m_drv[c]++;
          tgt = (m_state[c] == 1) ? lo : lc;
          if (lo && lc)              m_state[c] = 5;
          else if (tgt)              m_state[c] = (m_state[c] == 1) ? 2 : 0;
          else if (m_drv[c] == TRAVEL) m_state[c] = 5;
          else if (press) begin
            m_resume[c] = (m_state[c] == 1) ? 3 : 1;
            m_state[c]  = 4;
          end
        end
        4: if (press) begin m_state[c] = m_resume[c]; m_drv[c] = 0; end
        5: if (bus.fault_clr) begin m_state[c] = 4; m_resume[c] = 3; end
        default: m_state[c] = 5;
      endcase
      hb[c][2] = hb[c][1]; hb[c][1] = hb[c][0]; hb[c][0] = bus.button_press[c];
      ho[c][2] = ho[c][1]; ho[c][1] = ho[c][0]; ho[c][0] = bus.limit_open[c];
      hc[c][2] = hc[c][1]; hc[c][1] = hc[c][0]; hc[c][0] = bus.limit_closed[c];
    end
  endfunction

  task automatic compare_all();
    for (int c = 0; c < NUM_CH; c++) begin
      check_val($sformatf("state_ch%0d", c), bus.state_o[3*c +: 3], m_state[c]);
      check_val($sformatf("open_ch%0d", c), bus.open_cw[c], m_state[c] == 1);
      check_val($sformatf("close_ch%0d", c), bus.close_ccw[c], m_state[c] == 3);
      check_val($sformatf("fault_ch%0d", c), bus.fault[c], m_state[c] == 5);
    end
    check_val("no_overlap", |(bus.open_cw & bus.close_ccw), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse(input int c);
    bus.button_press[c] = 1'b1;
    tick(2);
    bus.button_press[c] = 1'b0;
    tick(4);
  endtask

  task automatic clr_pulse();
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    int hi;
    int entries;
    int prev;

    bus.button_press = '0;
    bus.limit_open   = '0;
    bus.limit_closed = '0;
    bus.fault_clr    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_val("reset_state_o", bus.state_o, 0);
    n_reset = 1'b1;
    tick(2);

    // ch0 open via 3-cycle press, then open end-stop
    bus.button_press[0] = 1'b1;
    tick(2);
    check_val("open_before_e3", bus.open_cw[0], 0);
    tick(1);
    check_val("open_after_e3", bus.open_cw[0], 1);
    bus.button_press[0] = 1'b0;
    tick(5);
    bus.limit_open[0] = 1'b1;
    tick(2);
    check_val("open_limit_latency", bus.open_cw[0], 1);
    tick(1);
    check_val("opened_drive_off", bus.open_cw[0], 0);
    check_val("opened_state", bus.state_o[2:0], 2);
    bus.limit_open[0] = 1'b0;
    tick(2);

    // close, stop mid-travel, reverse
    pulse(0);
    check_val("closing_drive", bus.close_ccw[0], 1);
    pulse(0);
    check_val("stopped_state", bus.state_o[2:0], 4);
    pulse(0);
    check_val("reverse_open", bus.open_cw[0], 1);
    bus.limit_open[0] = 1'b1;
    tick(3);
    bus.limit_open[0] = 1'b0;
    tick(1);

    // ch1 travel timeout, fault handling
    bus.button_press[1] = 1'b1;
    tick(2);
    bus.button_press[1] = 1'b0;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (bus.open_cw[1]) hi++;
    end
    check_val("ch1_drive_cycles", hi, TRAVEL);
    check_val("ch1_fault_state", bus.state_o[5:3], 5);
    check_val("ch1_fault_flag", bus.fault[1], 1);
    pulse(1);
    check_val("fault_ignores_press", bus.state_o[5:3], 5);
    clr_pulse();
    check_val("fault_clr_stopped", bus.state_o[5:3], 4);
    pulse(1);
    check_val("after_clr_closes", bus.close_ccw[1], 1);
    bus.limit_closed[1] = 1'b1;
    tick(3);
    bus.limit_closed[1] = 1'b0;
    tick(1);

    // ch0: limit beats simultaneous press; both limits fault
    pulse(0);
    bus.button_press[0] = 1'b1;
    bus.limit_closed[0] = 1'b1;
    tick(3);
    check_val("limit_beats_press", bus.state_o[2:0], 0);
    bus.button_press[0] = 1'b0;
    bus.limit_closed[0] = 1'b0;
    tick(3);
    pulse(0);
    bus.limit_open[0]   = 1'b1;
    bus.limit_closed[0] = 1'b1;
    tick(3);
    check_val("both_limits_fault", bus.state_o[2:0], 5);
    bus.limit_open[0]   = 1'b0;
    bus.limit_closed[0] = 1'b0;
    tick(1);
    clr_pulse();

    // simultaneous presses, ch1 times out while ch0 closes normally
    bus.button_press = 2'b11;
    tick(2);
    bus.button_press = 2'b00;
    tick(6);
    bus.limit_closed[0] = 1'b1;
    tick(3);
    bus.limit_closed[0] = 1'b0;
    tick(10);
    check_val("ch0_independent", bus.state_o[2:0], 0);
    check_val("ch1_timeout", bus.state_o[5:3], 5);
    clr_pulse();
    pulse(1);
    tick(2);

    // asynchronous reset mid-travel
    n_reset = 1'b0;
    #1;
    model_reset();
    check_val("async_drive_drop", bus.close_ccw[1], 0);
    check_val("async_state_o", bus.state_o, 0);
    tick(3);
    n_reset = 1'b1;
    tick(6);
    check_val("no_evt_after_rst", bus.state_o, 0);

    // held button gives exactly one event
    bus.button_press[0] = 1'b1;
    entries = 0;
    prev = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (bus.state_o[2:0] == 3'd1 && prev != 1) entries++;
      prev = int'(bus.state_o[2:0]);
    end
    check_val("held_button_events", entries, 1);
    bus.button_press[0] = 1'b0;
    clr_pulse();

    // random stimulus
    for (int k = 0; k < 10000; k++) begin
      if (!n_reset) n_reset = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 2999) == 0) n_reset = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0)  bus.button_press[c] = ~bus.button_press[c];
        if ($urandom_range(0, 59) == 0) bus.limit_open[c]   = ~bus.limit_open[c];
        if ($urandom_range(0, 59) == 0) bus.limit_closed[c] = ~bus.limit_closed[c];
      end
      bus.fault_clr = ($urandom_range(0, 29) == 0);
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
